uart_cmd_parser: RTL and testbench
==================================

# uart_cmd_parser

Line-oriented ASCII command parser sitting directly downstream of the UART receiver. It consumes the receiver's one-cycle byte strobes, assembles single-character commands terminated by CR or LF, and presents each validated command to the game controller over a valid/ready handshake. Malformed lines, stalled lines and dropped commands are reported on a one-cycle error strobe.

## Interface
- TIMEOUT_CLKS, 100_000_000: idle cycles allowed between bytes of one line before it is abandoned (1 s at 100 MHz); must be ≥ 2
- clk  in  1  system clock, 100 MHz
- reset_n  in  1  synchronous, active-low reset
- rx_data_valid  in  1  one-cycle strobe: rx_byte holds a received byte
- rx_byte  in  8  received byte, sampled only when rx_data_valid = 1
- cmd_valid  out  1  command available; held until accepted
- cmd_ready  in  1  consumer accepts the command this cycle
- cmd_type  out  2  1 = MOVE, 2 = NEW_GAME (0 never driven while cmd_valid = 1)
- cmd_cell  out  4  board cell 0..8 for MOVE; 0 for NEW_GAME
- err_valid  out  1  one-cycle error strobe
- err_code  out  2  0 = BAD_CHAR, 1 = BAD_LEN, 2 = TIMEOUT, 3 = OVERFLOW; valid only with err_valid

## Operation
- Byte classes: space 0x20 is ignored in every state. Terminator is 0x0D or 0x0A. Digit is 0x31..0x39, giving cell = byte − 0x31. New-game is 0x52 or 0x72. Anything else is other.
- FSM states: IDLE, GOT_CMD, DISCARD. Transitions occur only on a sampled byte or a timeout.
- IDLE:
  - Terminator: ignored, so empty lines and CRLF pairs are harmless.
  - Digit: latch MOVE and the cell, go to GOT_CMD.
  - New-game: latch NEW_GAME with cell 0, go to GOT_CMD.
  - Other: err BAD_CHAR, go to DISCARD.
- GOT_CMD:
  - Terminator: publish the latched command, go to IDLE.
  - Any other non-space byte: err BAD_LEN, go to DISCARD.
  - Timeout: err TIMEOUT, go to IDLE.
- DISCARD:
  - Terminator: go to IDLE, with no error.
  - Timeout: go to IDLE, with no error.
  - All other bytes are dropped silently.
- Publish:
  - If cmd_valid = 0, or cmd_valid = 1 and cmd_ready = 1 in the same cycle, load the output register.
  - Otherwise drop the new command and raise err OVERFLOW. The held command is unchanged.
- Handshake: a transfer occurs at a posedge with cmd_valid = 1 and cmd_ready = 1. cmd_type and cmd_cell stay stable while cmd_valid = 1 and cmd_ready = 0. cmd_ready is ignored while cmd_valid = 0.
- Timeout counter:
  - Width is $clog2(TIMEOUT_CLKS).
  - It clears to 0 on every sampled byte (including spaces) and on entry to IDLE.
  - It increments each cycle in GOT_CMD or DISCARD without a byte.
  - Timeout fires when the count equals TIMEOUT_CLKS − 1 with no byte that cycle. It never increments in IDLE.
- At most one error per cycle. err_valid is never asserted on two consecutive cycles from one byte.

## Timing
- Reset values: cmd_valid 0, cmd_type 0, cmd_cell 0, err_valid 0, err_code 0, FSM IDLE, counter 0.
- Latency: cmd_valid rises on the first posedge after the terminator's rx_data_valid cycle. A byte-triggered err_valid also pulses in that cycle. A TIMEOUT err_valid pulses in the cycle after the counter reaches TIMEOUT_CLKS − 1.
- cmd_valid falls on the posedge after a transfer, unless a new command loads in that same cycle; it then stays high with new values.
- A byte and a timeout in the same cycle: the byte wins and no timeout occurs.
- Back-to-back bytes on consecutive cycles are accepted; no rx throttling exists.
- reset_n low mid-line or with a held command clears everything. The partial line and the pending command are lost, and no error is reported.

## Structure
- Package ttt_uart_pkg holds:
  - cmd_type_t (CMD_NONE = 0, CMD_MOVE = 1, CMD_NEW_GAME = 2)
  - err_code_t
  - parser state enum
  - ASCII constants: CR, LF, SPACE, CHAR_1, CHAR_9, CHAR_R_UP, CHAR_R_LO
- No sub-module. Byte classification is a package function; the FSM, timeout counter and output register live in uart_cmd_parser.

## Test plan
- Bytes '5', CR with cmd_ready = 1 → one cycle of cmd_valid with MOVE, cell 4, no err. Then '9', LF → MOVE, cell 8.
- Bytes ' ', 'r', ' ', CR, LF → one NEW_GAME, cell 0. The trailing LF produces no error and no command.
- Bytes 'x', '3', CR → err BAD_CHAR once, no command. Bytes '1', '2', CR → err BAD_LEN once, no command. The next line '7', CR → MOVE, cell 6.
- TIMEOUT_CLKS = 50, bytes '4' then silence → err TIMEOUT exactly 50 cycles after the byte strobe. A following CR alone yields nothing.
- cmd_ready held 0: lines '1'+CR then '2'+CR → first command held stable, err OVERFLOW on the second. With cmd_ready = 1 in the second terminator's publish cycle → cell 1 replaces cell 0 and no error.
- reset_n low for 1 cycle after '6' (before CR) → all outputs at reset values. A subsequent CR yields no command.

Source files
------------

// File: rtl/ttt_uart_pkg.sv
// Shared types and ASCII constants for the UART command parser.
// Byte classification lives here so other blocks can classify bytes the same way.
package ttt_uart_pkg;

    typedef enum logic [1:0] {
        CMD_NONE     = 2'd0,
        CMD_MOVE     = 2'd1,
        CMD_NEW_GAME = 2'd2
    } cmd_type_t;

    typedef enum logic [1:0] {
        ERR_BAD_CHAR = 2'd0,
        ERR_BAD_LEN  = 2'd1,
        ERR_TIMEOUT  = 2'd2,
        ERR_OVERFLOW = 2'd3
    } err_code_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GOT_CMD = 2'd1,
        ST_DISCARD = 2'd2
    } parser_state_t;

    typedef enum logic [2:0] {
        BC_SPACE    = 3'd0,
        BC_TERM     = 3'd1,
        BC_DIGIT    = 3'd2,
        BC_NEW_GAME = 3'd3,
        BC_OTHER    = 3'd4
    } byte_class_t;

    localparam logic [7:0] CR        = 8'h0D;
    localparam logic [7:0] LF        = 8'h0A;
    localparam logic [7:0] SPACE     = 8'h20;
    localparam logic [7:0] CHAR_1    = 8'h31;
    localparam logic [7:0] CHAR_9    = 8'h39;
    localparam logic [7:0] CHAR_R_UP = 8'h52;
    localparam logic [7:0] CHAR_R_LO = 8'h72;

    function automatic byte_class_t classify_byte(input logic [7:0] b);
        if (b == SPACE)
            return BC_SPACE;
        if (b == CR || b == LF)
            return BC_TERM;
        if (b >= CHAR_1 && b <= CHAR_9)
            return BC_DIGIT;
        if (b == CHAR_R_UP || b == CHAR_R_LO)
            return BC_NEW_GAME;
        return BC_OTHER;
    endfunction

    // '1'..'9' map onto board cells 0..8.
    function automatic logic [3:0] digit_cell(input logic [7:0] b);
        return 4'(b - CHAR_1);
    endfunction

endpackage

// File: rtl/uart_cmd_parser.sv
// Assembles single-character command lines from UART bytes and hands them to the
// game controller over valid/ready; malformed, stalled and dropped lines strobe err_valid.
module uart_cmd_parser
    import ttt_uart_pkg::*;
#(
    parameter int unsigned TIMEOUT_CLKS = 100_000_000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx_data_valid,
    input  logic [7:0] rx_byte,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic [1:0] cmd_type,
    output logic [3:0] cmd_cell,
    output logic       err_valid,
    output logic [1:0] err_code
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CLKS);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CLKS - 1);

    parser_state_t    state;
    logic [CNT_W-1:0] tmo_cnt;
    cmd_type_t        pend_type;
    logic [3:0]       pend_cell;
    byte_class_t      rx_class;

    assign rx_class = classify_byte(rx_byte);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            tmo_cnt   <= '0;
            pend_type <= CMD_NONE;
            pend_cell <= 4'd0;
            cmd_valid <= 1'b0;
            cmd_type  <= 2'd0;
            cmd_cell  <= 4'd0;
            err_valid <= 1'b0;
            err_code  <= 2'd0;
        end else begin
            err_valid <= 1'b0;
            if (cmd_valid && cmd_ready)
                cmd_valid <= 1'b0;

            if (rx_data_valid) begin
                tmo_cnt <= '0;
                unique case (state)
                    ST_IDLE: begin
                        unique case (rx_class)
                            BC_DIGIT: begin
                                pend_type <= CMD_MOVE;
                                pend_cell <= digit_cell(rx_byte);
                                state     <= ST_GOT_CMD;
                            end
                            BC_NEW_GAME: begin
                                pend_type <= CMD_NEW_GAME;
                                pend_cell <= 4'd0;
                                state     <= ST_GOT_CMD;
                            end
                            BC_OTHER: begin
                                err_valid <= 1'b1;
                                err_code  <= ERR_BAD_CHAR;
                                state     <= ST_DISCARD;
                            end
                            default: ;
                        endcase
                    end
                    ST_GOT_CMD: begin
                        unique case (rx_class)
                            BC_SPACE: ;
                            BC_TERM: begin
                                state <= ST_IDLE;
                                // A transfer this cycle frees the output register for the new command.
                                if (!cmd_valid || cmd_ready) begin
                                    cmd_valid <= 1'b1;
                                    cmd_type  <= pend_type;
                                    cmd_cell  <= pend_cell;
                                end else begin
                                    err_valid <= 1'b1;
                                    err_code  <= ERR_OVERFLOW;
                                end
                            end
                            default: begin
                                err_valid <= 1'b1;
                                err_code  <= ERR_BAD_LEN;
                                state     <= ST_DISCARD;
                            end
                        endcase
                    end
                    ST_DISCARD: begin
                        if (rx_class == BC_TERM)
                            state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end else if (state != ST_IDLE) begin
                // Line stalled: abandon it, reporting only if a command was pending.
                if (tmo_cnt == TMO_LAST) begin
                    tmo_cnt <= '0;
                    state   <= ST_IDLE;
                    if (state == ST_GOT_CMD) begin
                        err_valid <= 1'b1;
                        err_code  <= ERR_TIMEOUT;
                    end
                end else begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Self-checking bench for uart_cmd_parser: directed scenarios plus randomized traffic
// compared cycle by cycle against a line-level reference model.
module tb_uart_cmd_parser;

    localparam int unsigned T = 50;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       rx_data_valid;
    logic [7:0] rx_byte;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_type;
    logic [3:0] cmd_cell;
    logic       err_valid;
    logic [1:0] err_code;

    int checks   = 0;
    int failures = 0;

    // Reference model: tracks the current line as a count of non-space characters.
    bit         m_valid     = 1'b0;
    logic [1:0] m_type      = 2'd0;
    logic [3:0] m_cell      = 4'd0;
    bit         m_err_valid = 1'b0;
    logic [1:0] m_err_code  = 2'd0;
    int         m_len       = 0;
    bit         m_bad       = 1'b0;
    int         m_gap       = 0;
    logic [1:0] m_pend_type = 2'd0;
    logic [3:0] m_pend_cell = 4'd0;

    always #5 clk = ~clk;

    uart_cmd_parser #(.TIMEOUT_CLKS(T)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .rx_data_valid (rx_data_valid),
        .rx_byte       (rx_byte),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_type      (cmd_type),
        .cmd_cell      (cmd_cell),
        .err_valid     (err_valid),
        .err_code      (err_code)
    );

    task automatic model_edge(input logic rst_n, input logic dv, input logic [7:0] b,
                              input logic rdy);
        bit xfer;
        bit publish;
        if (!rst_n) begin
            m_valid = 0; m_type = 0; m_cell = 0; m_err_valid = 0; m_err_code = 0;
            m_len = 0; m_bad = 0; m_gap = 0;
            return;
        end
        xfer        = m_valid && rdy;
        publish     = 0;
        m_err_valid = 0;
        if (dv) begin
            m_gap = 0;
            if (b == 8'h20) begin
            end else if (b == 8'h0D || b == 8'h0A) begin
                if (m_len == 1 && !m_bad)
                    publish = 1;
                m_len = 0;
                m_bad = 0;
            end else begin
                m_len++;
                if (m_len == 1) begin
                    if (b >= 8'h31 && b <= 8'h39) begin
                        m_pend_type = 2'd1;
                        m_pend_cell = 4'(b - 8'h31);
                    end else if (b == 8'h52 || b == 8'h72) begin
                        m_pend_type = 2'd2;
                        m_pend_cell = 4'd0;
                    end else begin
                        m_bad = 1; m_err_valid = 1; m_err_code = 2'd0;
                    end
                end else if (m_len == 2 && !m_bad) begin
                    m_bad = 1; m_err_valid = 1; m_err_code = 2'd1;
                end
            end
        end else if (m_len > 0) begin
            m_gap++;
            if (m_gap == int'(T)) begin
                if (!m_bad) begin
                    m_err_valid = 1; m_err_code = 2'd2;
                end
                m_len = 0; m_bad = 0; m_gap = 0;
            end
        end
        if (publish) begin
            if (!m_valid || rdy) begin
                m_valid = 1; m_type = m_pend_type; m_cell = m_pend_cell;
            end else begin
                m_err_valid = 1; m_err_code = 2'd3;
            end
        end else if (xfer) begin
            m_valid = 0;
        end
    endtask

    // One clock: drive at negedge, advance model at posedge, return 1 time unit later.
    task automatic step(input logic rst_n, input logic dv, input logic [7:0] b, input logic rdy);
        @(negedge clk);
        reset_n       = rst_n;
        rx_data_valid = dv;
        rx_byte       = b;
        cmd_ready     = rdy;
        @(posedge clk);
        model_edge(rst_n, dv, b, rdy);
        #1;
    endtask

    function automatic logic [7:0] rand_byte();
        int unsigned r = $urandom_range(0, 15);
        case (r)
            0, 1:             return 8'h20;
            2:                return 8'h0D;
            3:                return 8'h0A;
            4, 5, 6, 7, 8, 9: return 8'h31 + 8'($urandom_range(0, 8));
            10:               return 8'h52;
            11:               return 8'h72;
            default:          return 8'($urandom_range(0, 255));
        endcase
    endfunction

    task automatic test_reset();
        step(1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        checks++;
        if ({cmd_valid, cmd_type, cmd_cell, err_valid, err_code} !== 10'd0) begin
            failures++;
            $display("FAIL reset_values: got v=%b t=%0d c=%0d ev=%b ec=%0d, expected all 0",
                     cmd_valid, cmd_type, cmd_cell, err_valid, err_code);
        end
    endtask

    task automatic test_move();
        step(1'b1, 1'b1, 8'h35, 1'b1);
        step(1'b1, 1'b1, 8'h0D, 1'b1);
        checks++;
        if ({cmd_valid, cmd_type, cmd_cell, err_valid} !== {1'b1, 2'd1, 4'd4, 1'b0}) begin
            failures++;
            $display("FAIL move_5: got v=%b t=%0d c=%0d ev=%b, expected v=1 t=1 c=4 ev=0",
                     cmd_valid, cmd_type, cmd_cell, err_valid);
        end
        step(1'b1, 1'b0, 8'h00, 1'b1);
        checks++;
        if (cmd_valid !== 1'b0) begin
            failures++;
            $display("FAIL move_5_single_cycle: got v=%b, expected 0", cmd_valid);
        end
        step(1'b1, 1'b1, 8'h39, 1'b1);
        step(1'b1, 1'b1, 8'h0A, 1'b1);
        checks++;
        if ({cmd_valid, cmd_type, cmd_cell, err_valid} !== {1'b1, 2'd1, 4'd8, 1'b0}) begin
            failures++;
            $display("FAIL move_9: got v=%b t=%0d c=%0d ev=%b, expected v=1 t=1 c=8 ev=0",
                     cmd_valid, cmd_type, cmd_cell, err_valid);
        end
        step(1'b1, 1'b0, 8'h00, 1'b1);
    endtask

    task automatic test_new_game();
        step(1'b1, 1'b1, 8'h20, 1'b1);
        step(1'b1, 1'b1, 8'h72, 1'b1);
        step(1'b1, 1'b1, 8'h20, 1'b1);
        step(1'b1, 1'b1, 8'h0D, 1'b1);
        checks++;
        if ({cmd_valid, cmd_type, cmd_cell, err_valid} !== {1'b1, 2'd2, 4'd0, 1'b0}) begin
            failures++;
            $display("FAIL new_game: got v=%b t=%0d c=%0d ev=%b, expected v=1 t=2 c=0 ev=0",
                     cmd_valid, cmd_type, cmd_cell, err_valid);
        end
        step(1'b1, 1'b1, 8'h0A, 1'b1);
        checks++;
        if ({cmd_valid, err_valid} !== 2'b00) begin
            failures++;
            $display("FAIL crlf_harmless: got v=%b ev=%b, expected v=0 ev=0", cmd_valid, err_valid);
        end
    endtask

    task automatic test_errors();
        int errs = 0;
        int cmds = 0;
        step(1'b1, 1'b1, 8'h78, 1'b1);
        checks++;
        if ({err_valid, err_code} !== {1'b1, 2'd0}) begin
            failures++;
            $display("FAIL bad_char: got ev=%b ec=%0d, expected ev=1 ec=0", err_valid, err_code);
        end
        step(1'b1, 1'b1, 8'h33, 1'b1); errs += int'(err_valid); cmds += int'(cmd_valid);
        step(1'b1, 1'b1, 8'h0D, 1'b1); errs += int'(err_valid); cmds += int'(cmd_valid);
        step(1'b1, 1'b1, 8'h31, 1'b1); errs += int'(err_valid); cmds += int'(cmd_valid);
        step(1'b1, 1'b1, 8'h32, 1'b1);
        checks++;
        if ({err_valid, err_code} !== {1'b1, 2'd1}) begin
            failures++;
            $display("FAIL bad_len: got ev=%b ec=%0d, expected ev=1 ec=1", err_valid, err_code);
        end
        cmds += int'(cmd_valid);
        step(1'b1, 1'b1, 8'h0D, 1'b1); errs += int'(err_valid); cmds += int'(cmd_valid);
        checks++;
        if (errs != 0 || cmds != 0) begin
            failures++;
            $display("FAIL discard_silent: got errs=%0d cmds=%0d, expected 0 and 0", errs, cmds);
        end
        step(1'b1, 1'b1, 8'h37, 1'b1);
        step(1'b1, 1'b1, 8'h0D, 1'b1);
        checks++;
        if ({cmd_valid, cmd_type, cmd_cell, err_valid} !== {1'b1, 2'd1, 4'd6, 1'b0}) begin
            failures++;
            $display("FAIL recover_7: got v=%b t=%0d c=%0d ev=%b, expected v=1 t=1 c=6 ev=0",
                     cmd_valid, cmd_type, cmd_cell, err_valid);
        end
        step(1'b1, 1'b0, 8'h00, 1'b1);
    endtask

    task automatic test_timeout();
        int first  = 0;
        int n_err  = 0;
        logic [1:0] code = 2'd0;
        step(1'b1, 1'b1, 8'h34, 1'b1);
        for (int k = 1; k <= int'(T) + 20; k++) begin
            step(1'b1, 1'b0, 8'h00, 1'b1);
            if (err_valid === 1'b1) begin
                n_err++;
                if (first == 0) begin
                    first = k;
                    code  = err_code;
                end
            end
        end
        checks++;
        if (first != int'(T)) begin
            failures++;
            $display("FAIL timeout_latency: got %0d cycles, expected %0d", first, T);
        end
        checks++;
        if (n_err != 1 || code !== 2'd2) begin
            failures++;
            $display("FAIL timeout_code: got count=%0d ec=%0d, expected count=1 ec=2", n_err, code);
        end
        step(1'b1, 1'b1, 8'h0D, 1'b1);
        checks++;
        if ({cmd_valid, err_valid} !== 2'b00) begin
            failures++;
            $display("FAIL cr_after_timeout: got v=%b ev=%b, expected 0 0", cmd_valid, err_valid);
        end
    endtask

    task automatic test_overflow();
        step(1'b1, 1'b1, 8'h31, 1'b0);
        step(1'b1, 1'b1, 8'h0D, 1'b0);
        step(1'b1, 1'b1, 8'h32, 1'b0);
        checks++;
        if ({cmd_valid, cmd_type, cmd_cell} !== {1'b1, 2'd1, 4'd0}) begin
            failures++;
            $display("FAIL held_stable: got v=%b t=%0d c=%0d, expected v=1 t=1 c=0",
                     cmd_valid, cmd_type, cmd_cell);
        end
        step(1'b1, 1'b1, 8'h0D, 1'b0);
        checks++;
        if ({cmd_valid, cmd_cell, err_valid, err_code} !== {1'b1, 4'd0, 1'b1, 2'd3}) begin
            failures++;
            $display("FAIL overflow: got v=%b c=%0d ev=%b ec=%0d, expected v=1 c=0 ev=1 ec=3",
                     cmd_valid, cmd_cell, err_valid, err_code);
        end
        step(1'b1, 1'b0, 8'h00, 1'b1);
        checks++;
        if (cmd_valid !== 1'b0) begin
            failures++;
            $display("FAIL drain_after_overflow: got v=%b, expected 0", cmd_valid);
        end
        step(1'b1, 1'b1, 8'h31, 1'b0);
        step(1'b1, 1'b1, 8'h0D, 1'b0);
        step(1'b1, 1'b1, 8'h32, 1'b0);
        step(1'b1, 1'b1, 8'h0D, 1'b1);
        checks++;
        if ({cmd_valid, cmd_type, cmd_cell, err_valid} !== {1'b1, 2'd1, 4'd1, 1'b0}) begin
            failures++;
            $display("FAIL replace_on_xfer: got v=%b t=%0d c=%0d ev=%b, expected v=1 t=1 c=1 ev=0",
                     cmd_valid, cmd_type, cmd_cell, err_valid);
        end
        step(1'b1, 1'b0, 8'h00, 1'b1);
    endtask

    task automatic test_reset_midline();
        step(1'b1, 1'b1, 8'h31, 1'b0);
        step(1'b1, 1'b1, 8'h0D, 1'b0);
        step(1'b1, 1'b1, 8'h36, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        checks++;
        if ({cmd_valid, cmd_type, cmd_cell, err_valid, err_code} !== 10'd0) begin
            failures++;
            $display("FAIL reset_midline: got v=%b t=%0d c=%0d ev=%b ec=%0d, expected all 0",
                     cmd_valid, cmd_type, cmd_cell, err_valid, err_code);
        end
        step(1'b1, 1'b1, 8'h0D, 1'b1);
        checks++;
        if ({cmd_valid, err_valid} !== 2'b00) begin
            failures++;
            $display("FAIL cr_after_reset: got v=%b ev=%b, expected 0 0", cmd_valid, err_valid);
        end
    endtask

    task automatic test_random();
        int quiet = 0;
        logic dv;
        for (int i = 0; i < 4000; i++) begin
            if (quiet > 0) begin
                dv = 1'b0;
                quiet--;
            end else begin
                dv = ($urandom_range(0, 2) == 0);
                if ($urandom_range(0, 59) == 0)
                    quiet = int'($urandom_range(30, 70));
            end
            step(logic'($urandom_range(0, 799) != 0), dv, rand_byte(),
                 logic'($urandom_range(0, 1)));
            checks++;
            if (cmd_valid !== m_valid || err_valid !== m_err_valid) begin
                failures++;
                $display("FAIL rand_strobes cycle %0d: got v=%b ev=%b, expected v=%b ev=%b",
                         i, cmd_valid, err_valid, m_valid, m_err_valid);
            end
            if (m_valid) begin
                checks++;
                if (cmd_type !== m_type || cmd_cell !== m_cell) begin
                    failures++;
                    $display("FAIL rand_cmd cycle %0d: got t=%0d c=%0d, expected t=%0d c=%0d",
                             i, cmd_type, cmd_cell, m_type, m_cell);
                end
            end
            if (m_err_valid) begin
                checks++;
                if (err_code !== m_err_code) begin
                    failures++;
                    $display("FAIL rand_err cycle %0d: got ec=%0d, expected ec=%0d",
                             i, err_code, m_err_code);
                end
            end
        end
    endtask

    initial begin
        reset_n       = 1'b0;
        rx_data_valid = 1'b0;
        rx_byte       = 8'h00;
        cmd_ready     = 1'b0;
        test_reset();
        test_move();
        test_new_game();
        test_errors();
        test_timeout();
        test_overflow();
        test_reset_midline();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
